// File: rtl/ecpeta_pipe.sv
// Two-stage pipelined ECPETA approximate adder with exact/approx mode per transaction,
// parallel exact reference for per-result error, and saturating accuracy statistics.
module ecpeta_pipe #(
  parameter int N     = 16,
  parameter int K     = 8,
  parameter int CNT_W = 32,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic [N:0]       err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_cnt,
  output logic [ACC_W-1:0] err_acc
);

  localparam int H  = N - K;
  localparam int SW = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic             rdy_q;
  logic             s1_v_q, mode_q, c_q;
  logic [H-1:0]     ah_q, bh_q;
  logic [K-1:0]     lo_apx_q;
  logic [K:0]       lo_ex_q;
  logic             ov_q, cout_q;
  logic [N-1:0]     sum_q;
  logic [N:0]       err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic             s1_load, s2_load, in_fire, out_fire;
  logic             c_d;
  logic [K-1:0]     lo_apx_d;
  logic [K:0]       lo_ex_d;
  logic [H:0]       hi_ex, hi_ap;
  logic [N:0]       ex_full, res_full, err_d;
  logic [SW-1:0]    acc_sum;

  // Ready is derived only from pipeline occupancy and downstream ready, never from in_valid.
  assign s2_load  = ~ov_q | out_ready;
  assign s1_load  = rdy_q & (~s1_v_q | s2_load);
  assign in_ready = s1_load;
  assign in_fire  = in_valid & s1_load;
  assign out_fire = ov_q & out_ready;

  always_comb begin
    c_d      = a[K-1] & b[K-1];
    lo_apx_d = c_d ? '1 : (a[K-1:0] | b[K-1:0]);
    lo_ex_d  = {1'b0, a[K-1:0]} + {1'b0, b[K-1:0]};
  end

  always_comb begin
    hi_ex    = {1'b0, ah_q} + {1'b0, bh_q} + {{H{1'b0}}, lo_ex_q[K]};
    hi_ap    = {1'b0, ah_q} + {1'b0, bh_q} + {{H{1'b0}}, c_q};
    ex_full  = {hi_ex, lo_ex_q[K-1:0]};
    res_full = mode_q ? {hi_ap, lo_apx_q} : ex_full;
    err_d    = (res_full >= ex_full) ? (res_full - ex_full) : (ex_full - res_full);
  end

  always_comb begin
    acc_sum = SW'(acc_q) + SW'(err_q);
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (clr_stats) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (out_fire) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      acc_d = (acc_sum > ACC_MAX) ? '1 : ACC_W'(acc_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      ah_q     <= '0;
      bh_q     <= '0;
      lo_apx_q <= '0;
      lo_ex_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_load) s1_v_q <= in_valid;
      if (in_fire) begin
        mode_q   <= approx_en;
        c_q      <= c_d;
        ah_q     <= a[N-1:K];
        bh_q     <= b[N-1:K];
        lo_apx_q <= lo_apx_d;
        lo_ex_q  <= lo_ex_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      if (s2_load) begin
        ov_q <= s1_v_q;
        if (s1_v_q) begin
          {cout_q, sum_q} <= res_full;
          err_q           <= err_d;
        end
      end
    end
  end

  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign op_cnt    = cnt_q;
  assign err_acc   = acc_q;

endmodule

// File: tb/tb_ecpeta_pipe.sv
// Self-checking bench: two DUT instances (default and K=N-1 with narrow stats) share stimulus
// and are checked against an arithmetic reference model, a result queue and vector tables.
module tb_ecpeta_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, approx_en, clr_stats;
  logic [15:0] a, b;

  logic        in_ready0, out_valid0, cout0;
  logic [15:0] sum0;
  logic [16:0] err0;
  logic [31:0] op_cnt0;
  logic [39:0] err_acc0;

  logic        in_ready1, out_valid1, cout1;
  logic [15:0] sum1;
  logic [16:0] err1;
  logic [2:0]  op_cnt1;
  logic [7:0]  err_acc1;

  always #5 clk = ~clk;

  ecpeta_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .approx_en(approx_en), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
    .cout(cout0), .err(err0), .clr_stats(clr_stats), .op_cnt(op_cnt0), .err_acc(err_acc0)
  );

  ecpeta_pipe #(.N(16), .K(15), .CNT_W(3), .ACC_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .approx_en(approx_en), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
    .cout(cout1), .err(err1), .clr_stats(clr_stats), .op_cnt(op_cnt1), .err_acc(err_acc1)
  );

  typedef struct { logic [16:0] r0, e0, r1, e1; } exp_t;
  typedef struct { logic [15:0] a, b; logic m; logic [15:0] s; logic c; logic [16:0] e; } vec_t;

  exp_t q[$];
  vec_t tbl[7];
  int n_chk = 0, n_fail = 0;
  logic acc_f, ofire, seen_ov;
  longint unsigned m_op0, m_acc0, m_op1, m_acc1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_res(input logic [15:0] x, y, input logic m, input int k);
    int unsigned xi, yi, mask, c, lo, hi;
    xi = x; yi = y;
    if (!m) return 17'(xi + yi);
    mask = (32'd1 << k) - 1;
    c    = (xi >> (k - 1)) & (yi >> (k - 1)) & 1;
    lo   = (c != 0) ? mask : ((xi | yi) & mask);
    hi   = (xi >> k) + (yi >> k) + c;
    return 17'((hi << k) | lo);
  endfunction

  function automatic logic [16:0] model_err(input logic [15:0] x, y, input logic m, input int k);
    int unsigned ex, r;
    ex = 32'(x) + 32'(y);
    r  = 32'(model_res(x, y, m, k));
    return 17'((r >= ex) ? r - ex : ex - r);
  endfunction

  function automatic longint unsigned sadd(input longint unsigned v, inc, mx);
    return (v + inc > mx) ? mx : v + inc;
  endfunction

  task automatic clear_model();
    m_op0 = 0; m_acc0 = 0; m_op1 = 0; m_acc1 = 0;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update queue and stats model.
  task automatic step(input logic iv, input logic [15:0] xa, xb, input logic m,
                      input logic ordy, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = xa; b = xb; approx_en = m; out_ready = ordy; clr_stats = clr;
    #1;
    acc_f   = iv & in_ready0;
    ofire   = out_valid0 & ordy;
    seen_ov = out_valid0;
    chk("ready_match", in_ready1, in_ready0);
    chk("op_cnt0", op_cnt0, m_op0);
    chk("err_acc0", err_acc0, m_acc0);
    chk("op_cnt1", op_cnt1, m_op1);
    chk("err_acc1", err_acc1, m_acc1);
    if (out_valid0) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = q[0];
        chk("res0", {cout0, sum0}, e.r0);
        chk("err0", err0, e.e0);
        chk("res1", {cout1, sum1}, e.r1);
        chk("err1", err1, e.e1);
        chk("valid_match", out_valid1, 1);
        if (ofire) begin
          void'(q.pop_front());
          m_op0  = sadd(m_op0, 1, 64'hFFFF_FFFF);
          m_acc0 = sadd(m_acc0, e.e0, 64'hFF_FFFF_FFFF);
          m_op1  = sadd(m_op1, 1, 7);
          m_acc1 = sadd(m_acc1, e.e1, 255);
        end
      end
    end
    if (clr) clear_model();
    if (acc_f) begin
      e.r0 = model_res(xa, xb, m, 8);  e.e0 = model_err(xa, xb, m, 8);
      e.r1 = model_res(xa, xb, m, 15); e.e1 = model_err(xa, xb, m, 15);
      q.push_back(e);
    end
    chk("occupancy", q.size() <= 2, 1);
  endtask

  task automatic run_txn(input logic [15:0] xa, xb, input logic m);
    int t;
    t = 0;
    do begin step(1, xa, xb, m, 1, 0); t++; end while (!acc_f && t < 20);
    chk("accept_timeout", acc_f, 1);
    t = 0;
    do begin step(0, 0, 0, 0, 1, 0); t++; end while (!ofire && t < 20);
    chk("output_timeout", ofire, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    tbl[0] = '{16'h1234, 16'h5678, 1'b1, 16'h687C, 1'b0, 17'd48};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 17'd1};
    tbl[2] = '{16'h00C0, 16'h0080, 1'b1, 16'h01FF, 1'b0, 17'd191};
    tbl[3] = '{16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0, 17'd0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 17'd0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 17'd0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 17'd1};

    rst = 1'b1; in_valid = 0; out_ready = 0; approx_en = 0; clr_stats = 0; a = '0; b = '0;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_sum", {cout0, sum0}, 0);
    chk("rst_err", err0, 0);
    chk("rst_stats", {op_cnt0, err_acc0}, 0);
    @(negedge clk) rst = 1'b0;
    step(0, 0, 0, 0, 1, 0);
    chk("ready_after_reset", in_ready0, 1);

    // Vector table, one transaction at a time, with latency measured on each.
    for (int i = 0; i < 7; i++) begin
      step(1, tbl[i].a, tbl[i].b, tbl[i].m, 1, 0);
      chk("tbl_accept", acc_f, 1);
      lat = 0;
      do begin step(0, 0, 0, 0, 1, 0); lat++; end while (!seen_ov && lat < 10);
      chk("tbl_latency", lat, 2);
      chk("tbl_sum", sum0, tbl[i].s);
      chk("tbl_cout", cout0, tbl[i].c);
      chk("tbl_err", err0, tbl[i].e);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("tbl_op_cnt", op_cnt0, 7);
    chk("tbl_err_acc", err_acc0, 241);
    chk("k15_op_cnt_sat", op_cnt1, 7);

    // Narrow accumulator saturation on the K=N-1 instance (128 per transaction).
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("clr_idle", {op_cnt0, err_acc0, op_cnt1, err_acc1}, 0);
    run_txn(16'h00C0, 16'h0080, 1);
    run_txn(16'h00C0, 16'h0080, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("acc8_sat", err_acc1, 8'hFF);
    chk("acc8_opcnt", op_cnt1, 2);
    chk("acc40_two", err_acc0, 382);

    // Clear coinciding with a transfer, after holding the output for two cycles.
    step(1, 16'hABCD, 16'h1357, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_valid", out_valid0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("clr_fire", ofire, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("clr_with_fire", {op_cnt0, err_acc0, op_cnt1, err_acc1}, 0);

    // Backpressure: 4 offered, 2 accepted, then drain in order.
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), 1, 0, 0);
      if (acc_f) cnt++;
    end
    chk("bp_accepted", cnt, 2);
    chk("bp_in_ready", in_ready0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1, 0);
      if (ofire) cnt++;
    end
    chk("bp_drained", cnt, 2);
    chk("bp_queue_empty", q.size(), 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           1'(($urandom % 4) != 0), 1'(($urandom % 64) == 0));
    repeat (4) step(0, 0, 0, 0, 1, 0);
    run_txn(16'h00C0, 16'h0080, 1);
    step(0, 0, 0, 0, 1, 0);

    // Reset with two transactions in flight.
    step(1, 16'h0101, 16'h0202, 1, 0, 0);
    step(1, 16'h0303, 16'h0404, 1, 0, 0);
    chk("pre_rst_accept", acc_f, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", out_valid0, 1);
    chk("pre_rst_stats_nonzero", op_cnt0 != 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {out_valid0, out_valid1}, 0);
    chk("mid_rst_ready", in_ready0, 0);
    chk("mid_rst_stats", {op_cnt0, err_acc0, op_cnt1, err_acc1}, 0);
    q.delete();
    clear_model();
    @(negedge clk) rst = 1'b0;
    step(0, 0, 0, 0, 1, 0);
    step(1, 16'h1234, 16'h5678, 1, 1, 0);
    chk("post_rst_accept", acc_f, 1);
    lat = 0;
    do begin step(0, 0, 0, 0, 1, 0); lat++; end while (!seen_ov && lat < 10);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_sum", sum0, 16'h687C);
    step(0, 0, 0, 0, 1, 0);
    chk("post_rst_op_cnt", op_cnt0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
